multi_shift_register: RTL and testbench

Parametrised universal shift register with a start/done-handshaked multi-bit shift engine. It holds an N-bit word, can be cleared or parallel-loaded, and on command shifts the word left or right by a programmable amount, STEP bits per clock, in logical, arithmetic, rotate or serial-fill mode. It is the general-purpose shifter for datapaths that need variable-distance shifts with a completion flag, such as normalisers, serial converters and multi-cycle multiplier/divider loops.

---
 rtl/multi_shift_register.sv | 156 +++++++++++++++
 tb/tb_multi_shift_register.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_shift_register.sv
// -----------------------------------------------------------------------------
// multi_shift_register
//
// Universal N-bit shift register with a start/done handshake. The word can be
// cleared, parallel-loaded, or shifted left/right by a programmable distance,
// at most STEP bits per clock, in logical, arithmetic, rotate or serial-fill
// mode.
//
// Ports
//   clk     in   1    clock, rising edge
//   rst     in   1    asynchronous reset, active low
//   clr     in   1    synchronous clear of the word, aborts a shift in progress
//   ld      in   1    parallel load of din (idle only)
//   din     in   N    parallel load data
//   start   in   1    begin a shift of amt positions (idle only)
//   amt     in   AW   shift distance, saturates at N
//   dir     in   1    0 = right (toward bit 0), 1 = left
//   mode    in   2    00 logical, 01 arithmetic, 10 rotate, 11 serial fill
//   serIn   in   1    fill bit for serial mode, sampled on every shift cycle
//   dout    out  N    current word
//   serOut  out  1    last bit shifted out of the word
//   busy    out  1    high while a shift is in progress
//   done    out  1    one-cycle completion pulse
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting; honours ld and start
// SHIFT | moving min(STEP, rem) bits per clock until rem reaches zero
// -----------------------------------------------------------------------------
module multi_shift_register #(
    parameter  int N    = 32,
    parameter  int STEP = 1,
    localparam int AW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          ld,
    input  logic [N-1:0]  din,
    input  logic          start,
    input  logic [AW-1:0] amt,
    input  logic          dir,
    input  logic [1:0]    mode,
    input  logic          serIn,
    output logic [N-1:0]  dout,
    output logic          serOut,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    state_t        state;
    logic [AW-1:0] rem;
    logic          dir_q;
    logic [1:0]    mode_q;

    logic [AW-1:0] amt_sat;
    logic [AW-1:0] k_aw;
    logic [N-1:0]  nxt_word;
    logic          nxt_ser;
    logic          out_bit;
    logic          fill;

    assign amt_sat = (amt > AW'(N)) ? AW'(N) : amt;
    assign k_aw    = (rem > AW'(STEP)) ? AW'(STEP) : rem;

    // A k-bit shift is built as k chained 1-bit shifts. This keeps every mode
    // exact: arithmetic fill keeps copying the unchanged MSB, rotate wraps
    // each expelled bit, and serOut ends up holding the last bit expelled.
    always_comb begin
        nxt_word = dout;
        nxt_ser  = serOut;
        out_bit  = 1'b0;
        fill     = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (i < int'(k_aw)) begin
                out_bit = dir_q ? nxt_word[N-1] : nxt_word[0];
                case (mode_q)
                    MODE_LOG: fill = 1'b0;
                    MODE_ARI: fill = dir_q ? 1'b0 : nxt_word[N-1];
                    MODE_ROT: fill = out_bit;
                    default:  fill = serIn;
                endcase
                if (dir_q) begin
                    nxt_word = {nxt_word[N-2:0], fill};
                end else begin
                    nxt_word = {fill, nxt_word[N-1:1]};
                end
                nxt_ser = out_bit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            dout   <= '0;
            serOut <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rem    <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'b00;
        end else if (clr) begin
            state  <= IDLE;
            dout   <= '0;
            serOut <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rem    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        dout <= din;
                    end else if (start) begin
                        dir_q  <= dir;
                        mode_q <= mode;
                        rem    <= amt_sat;
                        // Zero distance completes without ever entering SHIFT.
                        if (amt_sat == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    dout   <= nxt_word;
                    serOut <= nxt_ser;
                    rem    <= rem - k_aw;
                    if (rem == k_aw) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_shift_register.sv
module tb_multi_shift_register;

    localparam int N  = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          ld;
    logic [N-1:0]  din;
    logic          start;
    logic [AW-1:0] amt;
    logic          dir;
    logic [1:0]    mode;
    logic          serIn;

    logic [N-1:0]  dout0, dout1, dout2;
    logic          so0, so1, so2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;

    // Three instances share the inputs; cur picks the one being checked.
    multi_shift_register #(.N(N), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .start(start),
        .amt(amt), .dir(dir), .mode(mode), .serIn(serIn),
        .dout(dout0), .serOut(so0), .busy(busy0), .done(done0)
    );
    multi_shift_register #(.N(N), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .start(start),
        .amt(amt), .dir(dir), .mode(mode), .serIn(serIn),
        .dout(dout1), .serOut(so1), .busy(busy1), .done(done1)
    );
    multi_shift_register #(.N(N), .STEP(8)) u_s8 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .start(start),
        .amt(amt), .dir(dir), .mode(mode), .serIn(serIn),
        .dout(dout2), .serOut(so2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int           cur;
    logic [N-1:0] c_dout;
    logic         c_so, c_busy, c_done;

    always_comb begin
        c_dout = dout0;
        c_so   = so0;
        c_busy = busy0;
        c_done = done0;
        case (cur)
            1: begin c_dout = dout1; c_so = so1; c_busy = busy1; c_done = done1; end
            2: begin c_dout = dout2; c_so = so2; c_busy = busy2; c_done = done2; end
            default: ;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All helper tasks begin and end just after a falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic load(input logic [31:0] d);
        din = d;
        ld  = 1'b1;
        tick();
        ld  = 1'b0;
    endtask

    task automatic run_shift(input logic [AW-1:0] a, input logic d, input logic [1:0] m,
                             input logic [7:0] ser, output int cycles, output int busy_cnt);
        amt   = a;
        dir   = d;
        mode  = m;
        serIn = ser[0];
        start = 1'b1;
        tick();
        start    = 1'b0;
        cycles   = 0;
        busy_cnt = 0;
        while (!c_done && cycles < 80) begin
            if (c_busy) busy_cnt++;
            tick();
            cycles++;
            serIn = ser[cycles % 8];
        end
    endtask

    typedef struct {
        int            sel;
        logic [31:0]   din;
        logic [AW-1:0] amt;
        logic          dir;
        logic [1:0]    mode;
        logic [7:0]    ser;
        logic [31:0]   exp_dout;
        logic          exp_so;
        int            exp_k;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, bcnt, cnt;
        logic saw_done;

        //          sel din            amt    dir   mode   ser     exp_dout       so    k
        vecs[0]  = '{0, 32'h8000_00F0, 6'd4,  1'b0, 2'b01, 8'h00, 32'hF800_000F, 1'b0, 4};
        vecs[1]  = '{1, 32'h1234_5678, 6'd10, 1'b1, 2'b10, 8'h00, 32'hD159_E048, 1'b0, 3};
        vecs[2]  = '{2, 32'hFFFF_FFFF, 6'd40, 1'b0, 2'b00, 8'h00, 32'h0000_0000, 1'b1, 4};
        vecs[3]  = '{0, 32'h0000_0000, 6'd3,  1'b0, 2'b11, 8'h05, 32'hA000_0000, 1'b0, 3};
        vecs[4]  = '{0, 32'h8000_0001, 6'd1,  1'b1, 2'b01, 8'h00, 32'h0000_0002, 1'b1, 1};
        vecs[5]  = '{1, 32'hF000_000F, 6'd5,  1'b1, 2'b00, 8'h00, 32'h0000_01E0, 1'b0, 2};
        vecs[6]  = '{2, 32'hDEAD_BEEF, 6'd32, 1'b0, 2'b10, 8'h00, 32'hDEAD_BEEF, 1'b1, 4};
        vecs[7]  = '{1, 32'h5555_AAAA, 6'd0,  1'b0, 2'b00, 8'h00, 32'h5555_AAAA, 1'b0, 0};
        vecs[8]  = '{1, 32'h8000_0040, 6'd6,  1'b0, 2'b01, 8'h00, 32'hFE00_0001, 1'b0, 2};
        vecs[9]  = '{2, 32'h0000_0000, 6'd3,  1'b1, 2'b11, 8'hFF, 32'h0000_0007, 1'b0, 1};
        vecs[10] = '{0, 32'h0000_0003, 6'd2,  1'b0, 2'b10, 8'h00, 32'hC000_0000, 1'b1, 2};
        vecs[11] = '{1, 32'h0000_0000, 6'd33, 1'b0, 2'b11, 8'h01, 32'h0000_000F, 1'b0, 8};

        cur   = 0;
        rst   = 1'b0;
        clr   = 1'b0;
        ld    = 1'b0;
        din   = '0;
        start = 1'b0;
        amt   = '0;
        dir   = 1'b0;
        mode  = 2'b00;
        serIn = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset dout s1", dout0, 32'h0);
        chk("reset dout s4", dout1, 32'h0);
        chk("reset dout s8", dout2, 32'h0);
        chk("reset flags", {29'd0, so0, busy0, done0}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            cur = vecs[i].sel;
            pulse_clr();
            load(vecs[i].din);
            run_shift(vecs[i].amt, vecs[i].dir, vecs[i].mode, vecs[i].ser, cyc, bcnt);
            chk($sformatf("v%0d cycles", i), cyc, vecs[i].exp_k);
            chk($sformatf("v%0d busy_cnt", i), bcnt, vecs[i].exp_k);
            chk($sformatf("v%0d dout", i), c_dout, vecs[i].exp_dout);
            chk($sformatf("v%0d serOut", i), 32'(c_so), 32'(vecs[i].exp_so));
            chk($sformatf("v%0d done", i), 32'(c_done), 32'd1);
            chk($sformatf("v%0d busy_at_done", i), 32'(c_busy), 32'd0);
            tick();
            chk($sformatf("v%0d done_drop", i), 32'(c_done), 32'd0);
        end

        // Clear during the second shift cycle aborts without done.
        cur = 0;
        pulse_clr();
        load(32'hFFFF_FFFF);
        amt = 6'd8; dir = 1'b0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("clr first_step", c_dout, 32'h7FFF_FFFF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr dout", c_dout, 32'h0);
        chk("clr busy", 32'(c_busy), 32'd0);
        chk("clr serOut", 32'(c_so), 32'd0);
        saw_done = 1'b0;
        for (int j = 0; j < 10; j++) begin
            saw_done |= c_done;
            tick();
        end
        chk("clr no_done", 32'(saw_done), 32'd0);

        // ld and start while shifting are ignored.
        pulse_clr();
        load(32'h0000_00FF);
        amt = 6'd4; dir = 1'b1; mode = 2'b00; start = 1'b1;
        tick();
        ld = 1'b1; din = 32'h0000_1234; start = 1'b1; amt = 6'd1; mode = 2'b10; dir = 1'b0;
        tick();
        ld = 1'b0; start = 1'b0;
        cnt = 1;
        while (!c_done && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("ignore cycles", cnt, 4);
        chk("ignore dout", c_dout, 32'h0000_0FF0);
        chk("ignore serOut", 32'(c_so), 32'd0);

        // ld and start together in idle: load wins, start dropped.
        pulse_clr();
        din = 32'hCAFE_F00D; ld = 1'b1; start = 1'b1; amt = 6'd4; dir = 1'b0; mode = 2'b00;
        tick();
        ld = 1'b0; start = 1'b0;
        chk("ldstart dout", c_dout, 32'hCAFE_F00D);
        chk("ldstart busy", 32'(c_busy), 32'd0);
        tick();
        chk("ldstart no_done", 32'(c_done), 32'd0);
        chk("ldstart dout_hold", c_dout, 32'hCAFE_F00D);

        // Back-to-back: a new start accepted in the done cycle.
        pulse_clr();
        load(32'h0000_0001);
        run_shift(6'd2, 1'b1, 2'b00, 8'h00, cyc, bcnt);
        chk("b2b first_dout", c_dout, 32'h0000_0004);
        chk("b2b first_done", 32'(c_done), 32'd1);
        amt = 6'd1; dir = 1'b1; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", 32'(c_busy), 32'd1);
        chk("b2b done_low", 32'(c_done), 32'd0);
        tick();
        chk("b2b second_done", 32'(c_done), 32'd1);
        chk("b2b second_dout", c_dout, 32'h0000_0008);

        // Asynchronous reset in the middle of a shift.
        cur = 2;
        pulse_clr();
        load(32'hFFFF_FFFF);
        amt = 6'd32; dir = 1'b0; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("arst pre_dout", c_dout, 32'h00FF_FFFF);
        chk("arst pre_serOut", 32'(c_so), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst dout", c_dout, 32'h0);
        chk("arst flags", {29'd0, c_so, c_busy, c_done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            saw_done |= c_done;
        end
        chk("arst no_done", 32'(saw_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
